// File: rtl/seq_pattern_gen.sv
// Serial bit-pattern transmitter: shifts a latched pattern out MSB-first,
// repeating it with an optional idle gap, and flags completion with done.
module seq_pattern_gen #(
  parameter int PW  = 16,
  parameter int LW  = 4,
  parameter int RW  = 4,
  parameter int GAP = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [PW-1:0] pattern,
  input  logic [LW-1:0] len,
  input  logic [RW-1:0] repeat_n,
  output logic          out_bit,
  output logic          valid,
  output logic          busy,
  output logic          done,
  output logic [2:0]    led
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_INIT = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    SEND = 3'b001,
    GAPS = 3'b010,
    DONE = 3'b011
  } state_t;

  state_t        state;
  logic [PW-1:0] pat;
  logic [LW-1:0] len_q;
  logic [LW-1:0] idx;
  logic [RW-1:0] rep;
  logic [GW-1:0] gcnt;
  logic [LW-1:0] len_c;

  // Out-of-range lengths are clamped to the widest pattern.
  always_comb begin
    len_c = len;
    if (int'(len) > PW - 1)
      len_c = LW'(PW - 1);
  end

  assign led = state;

  // Transmit FSM with registered serial outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      pat     <= '0;
      len_q   <= '0;
      idx     <= '0;
      rep     <= '0;
      gcnt    <= '0;
      out_bit <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (abort) begin
      state   <= IDLE;
      out_bit <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          out_bit <= 1'b0;
          valid   <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          if (start) begin
            state   <= SEND;
            pat     <= pattern;
            len_q   <= len_c;
            idx     <= len_c;
            rep     <= repeat_n;
            out_bit <= pattern[len_c];
            valid   <= 1'b1;
            busy    <= 1'b1;
          end
        end
        SEND: begin
          if (idx == '0) begin
            if (rep == '0) begin
              state   <= DONE;
              out_bit <= 1'b0;
              valid   <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              rep <= rep - RW'(1);
              if (GAP > 0) begin
                state   <= GAPS;
                gcnt    <= GAP_INIT;
                out_bit <= 1'b0;
                valid   <= 1'b0;
              end else begin
                idx     <= len_q;
                out_bit <= pat[len_q];
              end
            end
          end else begin
            idx     <= idx - LW'(1);
            out_bit <= pat[idx - LW'(1)];
          end
        end
        GAPS: begin
          if (gcnt == '0) begin
            state   <= SEND;
            idx     <= len_q;
            out_bit <= pat[len_q];
            valid   <= 1'b1;
          end else begin
            gcnt <= gcnt - GW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          out_bit <= 1'b0;
          valid   <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Testbench for seq_pattern_gen: two instances (GAP=2 and GAP=0) driven
// together and compared cycle by cycle with an arithmetic timeline model.
module tb_seq_pattern_gen;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] pattern;
  logic [3:0]  len;
  logic [3:0]  repeat_n;

  logic       ob2, v2, b2, d2;
  logic [2:0] led2;
  logic       ob0, v0, b0, d0;
  logic [2:0] led0;

  int compared;
  int mismatched;

  seq_pattern_gen #(.PW(16), .LW(4), .RW(4), .GAP(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .pattern(pattern), .len(len), .repeat_n(repeat_n),
    .out_bit(ob2), .valid(v2), .busy(b2), .done(d2), .led(led2)
  );

  seq_pattern_gen #(.PW(16), .LW(4), .RW(4), .GAP(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .pattern(pattern), .len(len), .repeat_n(repeat_n),
    .out_bit(ob0), .valid(v0), .busy(b0), .done(d0), .led(led0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] obs2();
    return {ob2, v2, b2, d2, led2};
  endfunction

  function automatic logic [6:0] obs0();
    return {ob0, v0, b0, d0, led0};
  endfunction

  function automatic int total(int g, int ln, int rp);
    return (rp + 1) * (ln + 1) + rp * g;
  endfunction

  // Expected {out_bit,valid,busy,done,led} c cycles after the start edge.
  function automatic logic [6:0] exp_at(int g, logic [15:0] p,
                                        int ln, int rp, int c);
    int t, per, o;
    t = total(g, ln, rp);
    per = ln + 1 + g;
    if (c < t) begin
      o = c % per;
      if (o <= ln) return {p[ln - o], 1'b1, 1'b1, 1'b0, 3'b001};
      return {1'b0, 1'b0, 1'b1, 1'b0, 3'b010};
    end
    if (c == t) return {1'b0, 1'b0, 1'b0, 1'b1, 3'b011};
    return 7'b0;
  endfunction

  // Start a transmission; returns at the negedge after the start edge.
  task automatic kick(input logic [15:0] p, input int ln, input int rp);
    pattern  = p;
    len      = 4'(ln);
    repeat_n = 4'(rp);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    pattern = '0;
    len = '0;
    repeat_n = '0;
    repeat (3) @(negedge clk);
    compared++;
    if (obs2() !== 7'b0) begin
      mismatched++;
      $display("FAIL reset_g2 got %b want %b", obs2(), 7'b0);
    end
    compared++;
    if (obs0() !== 7'b0) begin
      mismatched++;
      $display("FAIL reset_g0 got %b want %b", obs0(), 7'b0);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    compared++;
    if (obs2() !== 7'b0 || obs0() !== 7'b0) begin
      mismatched++;
      $display("FAIL idle_after_reset got %b/%b want 0", obs2(), obs0());
    end
  endtask

  // Directed or randomised transmission; perturb pulses start and
  // scrambles pattern while the transfer is in flight.
  task automatic test_tx(input string nm, input logic [15:0] p,
                         input int ln, input int rp, input bit perturb);
    int t0, t2, vc, bc, dc;
    logic [6:0] e;
    t0 = total(0, ln, rp);
    t2 = total(2, ln, rp);
    vc = 0; bc = 0; dc = 0;
    kick(p, ln, rp);
    for (int c = 0; c <= t2 + 1; c++) begin
      e = exp_at(2, p, ln, rp, c);
      compared++;
      if (obs2() !== e) begin
        mismatched++;
        $display("FAIL %s_g2 cyc %0d got %b want %b", nm, c, obs2(), e);
      end
      e = exp_at(0, p, ln, rp, c);
      compared++;
      if (obs0() !== e) begin
        mismatched++;
        $display("FAIL %s_g0 cyc %0d got %b want %b", nm, c, obs0(), e);
      end
      vc += int'(v2);
      bc += int'(b2);
      dc += int'(d2);
      if (perturb && c <= t0) begin
        start   = 1'($urandom_range(0, 1));
        pattern = 16'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    compared++;
    if (vc != (ln + 1) * (rp + 1) || bc != t2 || dc != 1) begin
      mismatched++;
      $display("FAIL %s_counts valid/busy/done %0d/%0d/%0d want %0d/%0d/1",
               nm, vc, bc, dc, (ln + 1) * (rp + 1), t2);
    end
  endtask

  task automatic test_abort();
    logic [6:0] e;
    int dc;
    dc = 0;
    kick(16'h002B, 5, 0);
    for (int c = 0; c < 3; c++) begin
      e = exp_at(2, 16'h002B, 5, 0, c);
      compared++;
      if (obs2() !== e) begin
        mismatched++;
        $display("FAIL abort_pre cyc %0d got %b want %b", c, obs2(), e);
      end
      if (c < 2) @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    compared++;
    if (obs2() !== 7'b0 || obs0() !== 7'b0) begin
      mismatched++;
      $display("FAIL abort_clear got %b/%b want 0", obs2(), obs0());
    end
    repeat (10) begin
      @(negedge clk);
      dc += int'(d2) + int'(d0) + int'(v2) + int'(v0);
    end
    compared++;
    if (dc != 0) begin
      mismatched++;
      $display("FAIL abort_quiet got %0d activity want 0", dc);
    end
  endtask

  task automatic test_start_abort_idle();
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    compared++;
    if (obs2() !== 7'b0 || obs0() !== 7'b0) begin
      mismatched++;
      $display("FAIL start_abort got %b/%b want 0", obs2(), obs0());
    end
    @(negedge clk);
    compared++;
    if (obs2() !== 7'b0) begin
      mismatched++;
      $display("FAIL start_abort_late got %b want 0", obs2());
    end
  endtask

  task automatic test_async_reset();
    logic [6:0] e;
    kick(16'h002B, 5, 2);
    repeat (6) @(negedge clk);
    e = exp_at(2, 16'h002B, 5, 2, 6);
    compared++;
    if (obs2() !== e) begin
      mismatched++;
      $display("FAIL areset_gap got %b want %b", obs2(), e);
    end
    #2 reset = 1'b0;
    #1;
    compared++;
    if (obs2() !== 7'b0 || obs0() !== 7'b0) begin
      mismatched++;
      $display("FAIL areset_now got %b/%b want 0", obs2(), obs0());
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      compared++;
      if (obs2() !== 7'b0 || obs0() !== 7'b0) begin
        mismatched++;
        $display("FAIL areset_idle got %b/%b want 0", obs2(), obs0());
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      test_tx("rand", 16'($urandom), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      repeat (int'($urandom_range(0, 2))) @(negedge clk);
    end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    test_reset();
    test_tx("single", 16'h002B, 5, 0, 1'b0);
    test_tx("repeat", 16'h002B, 5, 2, 1'b0);
    test_tx("len0", 16'h0001, 0, 3, 1'b0);
    test_tx("restart", 16'h002B, 5, 1, 1'b1);
    test_tx("maxrep", 16'hA5C3, 3, 15, 1'b0);
    test_tx("fullw", 16'hBEEF, 15, 1, 1'b0);
    test_abort();
    test_tx("after_abort", 16'h002B, 5, 0, 1'b0);
    test_start_abort_idle();
    test_async_reset();
    test_tx("after_reset", 16'h00F0, 7, 1, 1'b0);
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
